complex_subtractor: RTL and testbench



---
 rtl/complex_subtractor.sv | 59 +++++
 tb/tb_complex_subtractor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/complex_subtractor.sv
// Registered complex subtractor c = a - b for the FFT butterfly.
// Components are {real, imag}; optional saturation with per-component overflow flags.
module complex_subtractor #(
    parameter int WIDTH    = 16,
    parameter bit SATURATE = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] c,
    output logic [1:0]         ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Returns {overflow, result} for one component.
    function automatic logic [WIDTH:0] sub_comp(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0]   d;
        logic             o;
        logic [WIDTH-1:0] r;
        d = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        o = d[WIDTH] ^ d[WIDTH-1];
        r = d[WIDTH-1:0];
        if (o && SATURATE) begin
            r = d[WIDTH] ? MIN_VAL : MAX_VAL;
        end
        return {o, r};
    endfunction

    logic [WIDTH:0] re_res;
    logic [WIDTH:0] im_res;

    always_comb begin
        re_res = sub_comp(a[2*WIDTH-1:WIDTH], b[2*WIDTH-1:WIDTH]);
        im_res = sub_comp(a[WIDTH-1:0], b[WIDTH-1:0]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            c         <= '0;
            ovf       <= 2'b00;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c   <= {re_res[WIDTH-1:0], im_res[WIDTH-1:0]};
                ovf <= {re_res[WIDTH], im_res[WIDTH]};
            end
        end
    end

endmodule

// File: tb/tb_complex_subtractor.sv
// Directed-vector bench for complex_subtractor.
// Checks a saturating and a wrapping instance side by side.
module tb_complex_subtractor;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid, out_valid_w;
    logic [31:0] c, c_w;
    logic [1:0]  ovf, ovf_w;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    complex_subtractor #(.WIDTH(16), .SATURATE(1'b1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid), .c(c), .ovf(ovf)
    );

    complex_subtractor #(.WIDTH(16), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
        .out_valid(out_valid_w), .c(c_w), .ovf(ovf_w)
    );

    // Present one operand pair for one cycle; outputs settle 1 ns after the edge.
    task automatic apply(input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_valid = 1'b1;
        a = 32'h1234_5678;
        b = 32'h0001_0001;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, ovf, c} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset: got v=%b ovf=%b c=%h want 0/00/0", out_valid, ovf, c);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_equal;
        apply(32'h3FFF_3FFF, 32'h3FFF_3FFF);
        n_cmp++;
        if ({out_valid, ovf, c} !== {1'b1, 2'b00, 32'h0000_0000}) begin
            n_fail++;
            $display("FAIL equal: got v=%b ovf=%b c=%h want 1/00/00000000", out_valid, ovf, c);
        end
    endtask

    task automatic test_extremes;
        apply(32'h3FFF_3FFF, 32'hC000_C000);
        n_cmp++;
        if ({out_valid, ovf, c} !== {1'b1, 2'b00, 32'h7FFF_7FFF}) begin
            n_fail++;
            $display("FAIL max_pos: got v=%b ovf=%b c=%h want 1/00/7fff7fff", out_valid, ovf, c);
        end
        apply(32'hC000_C000, 32'h3FFF_3FFF);
        n_cmp++;
        if ({out_valid, ovf, c} !== {1'b1, 2'b00, 32'h8001_8001}) begin
            n_fail++;
            $display("FAIL max_neg: got v=%b ovf=%b c=%h want 1/00/80018001", out_valid, ovf, c);
        end
        n_cmp++;
        if ({ovf_w, c_w} !== {2'b00, 32'h8001_8001}) begin
            n_fail++;
            $display("FAIL max_neg_wrap: got ovf=%b c=%h want 00/80018001", ovf_w, c_w);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] ops [4];
        ops[0] = 32'h3FFF_0000;
        ops[1] = 32'h0000_3FFF;
        ops[2] = 32'hC000_0000;
        ops[3] = 32'h0000_C000;
        for (int i = 0; i < 4; i++) begin
            apply(ops[i], ops[i]);
            n_cmp++;
            if ({out_valid, ovf, c} !== {1'b1, 2'b00, 32'h0}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: got v=%b ovf=%b c=%h want 1/00/0", i, out_valid, ovf, c);
            end
        end
    endtask

    task automatic test_overflow;
        apply(32'h7FFF_8000, 32'hFFFF_0001);
        n_cmp++;
        if ({out_valid, ovf, c} !== {1'b1, 2'b11, 32'h7FFF_8000}) begin
            n_fail++;
            $display("FAIL ovf_sat: got v=%b ovf=%b c=%h want 1/11/7fff8000", out_valid, ovf, c);
        end
        n_cmp++;
        if ({out_valid_w, ovf_w, c_w} !== {1'b1, 2'b11, 32'h8000_7FFF}) begin
            n_fail++;
            $display("FAIL ovf_wrap: got v=%b ovf=%b c=%h want 1/11/80007fff", out_valid_w, ovf_w, c_w);
        end
        // real: -32768 - 0 fits; imag: 0 - (-32768) overflows
        apply(32'h8000_0000, 32'h0000_8000);
        n_cmp++;
        if ({ovf, c} !== {2'b01, 32'h8000_7FFF}) begin
            n_fail++;
            $display("FAIL bound_sat: got ovf=%b c=%h want 01/80007fff", ovf, c);
        end
        n_cmp++;
        if ({ovf_w, c_w} !== {2'b01, 32'h8000_8000}) begin
            n_fail++;
            $display("FAIL bound_wrap: got ovf=%b c=%h want 01/80008000", ovf_w, c_w);
        end
        // halves must not carry into each other
        apply(32'h0005_0000, 32'h0003_0001);
        n_cmp++;
        if ({ovf, c} !== {2'b00, 32'h0002_FFFF}) begin
            n_fail++;
            $display("FAIL no_carry: got ovf=%b c=%h want 00/0002ffff", ovf, c);
        end
    endtask

    task automatic test_hold;
        apply(32'h0064_FF9C, 32'h0032_0032);
        @(negedge clk);
        in_valid = 1'b0;
        a = 'x;
        b = 'x;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, ovf, c} !== {1'b0, 2'b00, 32'h0032_FF6A}) begin
            n_fail++;
            $display("FAIL hold: got v=%b ovf=%b c=%h want 0/00/0032ff6a", out_valid, ovf, c);
        end
    endtask

    task automatic test_async_reset;
        apply(32'h1000_2000, 32'h0001_0002);
        n_cmp++;
        if ({out_valid, c} !== {1'b1, 32'h0FFF_1FFE}) begin
            n_fail++;
            $display("FAIL pre_reset: got v=%b c=%h want 1/0fff1ffe", out_valid, c);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, ovf, c} !== 35'h0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b ovf=%b c=%h want 0/00/0", out_valid, ovf, c);
        end
        @(negedge clk);
        reset = 1'b0;
        in_valid = 1'b0;
        a = 32'h7FFF_7FFF;
        b = 32'h0001_0001;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({out_valid, ovf, c} !== 35'h0) begin
            n_fail++;
            $display("FAIL post_reset: got v=%b ovf=%b c=%h want 0/00/0", out_valid, ovf, c);
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_extremes();
        test_back_to_back();
        test_overflow();
        test_hold();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
